// File: rtl/block_dispatcher_if.sv
// Dispatcher <-> CU bundle: per-CU block indices, offer/acknowledge
// handshake and completion pulses.
interface block_dispatcher_if #(
   parameter int n_cu        = 4,
   parameter int index_width = 8
);
   logic [n_cu*index_width-1:0] row_index;
   logic [n_cu*index_width-1:0] column_index;
   logic [n_cu-1:0]             indexes_ready;
   logic [n_cu-1:0]             indexes_received;
   logic [n_cu-1:0]             result_ready;

   modport master (
      output row_index,
      output column_index,
      output indexes_ready,
      input  indexes_received,
      input  result_ready
   );

   modport slave (
      input  row_index,
      input  column_index,
      input  indexes_ready,
      output indexes_received,
      output result_ready
   );
endinterface

// File: rtl/block_dispatcher.sv
// Walks the C block grid row-major, hands (i,j) pairs to free CUs and
// counts completions until every block of the job is written back.
module block_dispatcher #(
   parameter int n_cu        = 4,
   parameter int index_width = 8,
   parameter int max_mu_log  = 8
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   input  logic                  i_Start,
   input  logic [31:0]           i_Config,
   output logic [max_mu_log-1:0] o_mu,
   output logic                  o_Busy,
   output logic                  o_Done,
   block_dispatcher_if.master    cu
);
   localparam int IW = index_width;

   typedef enum logic [1:0] {
      S_IDLE, S_DISPATCH, S_DRAIN, S_DONE
   } state_e;

   typedef enum logic [1:0] {
      SL_FREE, SL_OFFER, SL_BUSY
   } slot_e;

   state_e                  state_q, state_d;
   slot_e                   slot_q [n_cu];
   slot_e                   slot_d [n_cu];
   logic [7:0]              p_q, p_d;
   logic [max_mu_log-1:0]   mu_q, mu_d;
   logic [IW-1:0]           row_q, row_d;
   logic [IW-1:0]           col_q, col_d;
   logic [IW-1:0]           col_last;
   logic [15:0]             issued_q, issued_d;
   logic [15:0]             completed_q, completed_d;
   logic [15:0]             total_q, total_d;
   logic [15:0]             n_res;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    found;
   logic [n_cu-1:0]         ready_q, ready_d;
   logic [n_cu*IW-1:0]      rix_q, rix_d;
   logic [n_cu*IW-1:0]      cix_q, cix_d;
   logic                    unused_cfg;

   assign unused_cfg = ^i_Config[31:24];
   assign col_last   = IW'(p_q - 8'd1);

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      p_d         = p_q;
      mu_d        = mu_q;
      row_d       = row_q;
      col_d       = col_q;
      issued_d    = issued_q;
      total_d     = total_q;
      busy_d      = busy_q;
      done_d      = done_q;
      ready_d     = ready_q;
      rix_d       = rix_q;
      cix_d       = cix_q;
      n_res       = '0;
      found       = 1'b0;

      // Acks and results from any number of CUs land in the same cycle.
      for (int k = 0; k < n_cu; k++) begin
         if (slot_q[k] == SL_OFFER && cu.indexes_received[k]) begin
            slot_d[k]  = SL_BUSY;
            ready_d[k] = 1'b0;
         end
         if (slot_q[k] == SL_BUSY && cu.result_ready[k]) begin
            slot_d[k] = SL_FREE;
            n_res     = n_res + 16'd1;
         end
      end
      completed_d = completed_q + n_res;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (i_Start) begin
               p_d         = i_Config[15:8];
               mu_d        = max_mu_log'(i_Config[23:16]);
               total_d     = 16'(i_Config[7:0]) * 16'(i_Config[15:8]);
               row_d       = '0;
               col_d       = '0;
               issued_d    = '0;
               completed_d = '0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               state_d     = S_DISPATCH;
            end
         end
         S_DISPATCH: begin
            if (total_q == 16'd0) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               // Only slots already free before this edge are eligible.
               for (int k = 0; k < n_cu; k++) begin
                  if (!found && slot_q[k] == SL_FREE) begin
                     found                 = 1'b1;
                     slot_d[k]             = SL_OFFER;
                     ready_d[k]            = 1'b1;
                     rix_d[k*IW +: IW]     = row_q;
                     cix_d[k*IW +: IW]     = col_q;
                  end
               end
               if (found) begin
                  if (col_q == col_last) begin
                     col_d = '0;
                     row_d = row_q + 1'b1;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
                  issued_d = issued_q + 16'd1;
                  if (issued_d == total_q) state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (completed_d == total_q) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q     <= S_IDLE;
         p_q         <= '0;
         mu_q        <= '0;
         row_q       <= '0;
         col_q       <= '0;
         issued_q    <= '0;
         completed_q <= '0;
         total_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ready_q     <= '0;
         rix_q       <= '0;
         cix_q       <= '0;
         for (int k = 0; k < n_cu; k++) slot_q[k] <= SL_FREE;
      end else begin
         state_q     <= state_d;
         p_q         <= p_d;
         mu_q        <= mu_d;
         row_q       <= row_d;
         col_q       <= col_d;
         issued_q    <= issued_d;
         completed_q <= completed_d;
         total_q     <= total_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
         rix_q       <= rix_d;
         cix_q       <= cix_d;
         slot_q      <= slot_d;
      end
   end

   assign o_mu             = mu_q;
   assign o_Busy           = busy_q;
   assign o_Done           = done_q;
   assign cu.indexes_ready = ready_q;
   assign cu.row_index     = rix_q;
   assign cu.column_index  = cix_q;
endmodule
